// File: rtl/pov_pkg.sv
// Shared types and helpers for the POV frame sequencer.
// Holds the mode-switch FSM state encoding, the blank pixel value and the
// width helpers that size the ROM address and index buses.
package pov_pkg;

  // Mode-switch FSM: RUN shows the active mode, PEND waits for the next
  // revolution boundary, BLANK shows one black revolution after the swap.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    BLANK = 2'd2
  } pov_state_t;

  // Black pixel; sliced down to the pixel width at the point of use.
  localparam logic [63:0] PIX_BLACK = '0;

  // ceil(log2(value)), never below 1 so that every bus keeps at least one bit.
  function automatic int clog2_min1(input longint value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Width of an address spanning every mode, frame, LED and column.
  function automatic int addr_width(input int modes, input int frames,
                                    input int leds, input int width);
    return clog2_min1(longint'(modes) * longint'(frames) *
                      longint'(leds) * longint'(width));
  endfunction

endpackage

// File: rtl/pov_addr_gen.sv
// Stage 1 of the pixel fetch: column wrap, texture ROM address arithmetic
// and the registered ROM read request.
// Out-of-range LED indices still travel down the pipe (issued) but never
// raise rom_rd, so the output stage emits a black pixel for them.
module pov_addr_gen
  import pov_pkg::*;
#(
  parameter int LED_COUNT  = 52,
  parameter int TEX_WIDTH  = 256,
  parameter int THETA_BITS = 6,
  parameter int FRAMES     = 8,
  parameter int IW         = 6,
  parameter int MW         = 2,
  parameter int FW         = 3,
  parameter int CW         = 8,
  parameter int AW         = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [THETA_BITS-1:0] theta,
  input  logic [IW-1:0]         px_idx,
  input  logic [CW-1:0]         phase_offset,
  input  logic [MW-1:0]         mode,
  input  logic [FW-1:0]         frame,
  output logic [AW-1:0]         rom_addr,
  output logic                  rom_rd,
  output logic                  issued
);

  logic [CW-1:0] col;
  logic          in_range;
  logic [AW-1:0] addr_d;

  // Column = theta scaled to TEX_WIDTH columns plus the phase offset; the
  // cast back to CW bits is the wrap modulo TEX_WIDTH (a power of two).
  always_comb begin
    col      = CW'(({theta, {CW{1'b0}}} >> THETA_BITS) +
                   (THETA_BITS + CW)'(phase_offset));
    in_range = ({1'b0, px_idx} < (IW + 1)'(LED_COUNT));
    addr_d   = AW'(((AW'(mode) * AW'(FRAMES) + AW'(frame)) * AW'(LED_COUNT) +
                    AW'(px_idx)) * AW'(TEX_WIDTH) + AW'(col));
  end

  // Stage-1 register: address and read strobe toward the ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      rom_rd   <= 1'b0;
      issued   <= 1'b0;
    end else begin
      issued <= req;
      rom_rd <= req && in_range;
      if (req) begin
        rom_addr <= addr_d;
      end
    end
  end

endmodule

// File: rtl/pov_frame_sequencer.sv
// POV frame sequencer: turns angle + LED requests into texture ROM reads
// and returns pixels two cycles later with a valid strobe.
// Owns the mode-switch FSM (RUN/PEND/BLANK), the animation frame counter
// and the output stage.
// Optional build macro POV_STALL_BLANK_EN: blanks pixels when no rev_pulse
// has arrived for STALL_CYCLES clocks (rotor stopped).
//
// Handshake: px_req is a one-cycle request, accepted every cycle with no
// backpressure; each accepted request yields exactly one pixel_valid pulse
// two cycles later, in request order, with pixel_out valid in that cycle.
module pov_frame_sequencer
  import pov_pkg::*;
#(
  parameter int  LED_COUNT    = 52,
  parameter int  TEX_WIDTH    = 256,
  parameter int  THETA_BITS   = 6,
  parameter int  NUM_MODES    = 4,
  parameter int  FRAMES       = 8,
  parameter int  FRAME_DIV    = 4,
  parameter int  PIX_W        = 24,
  parameter int  STALL_CYCLES = 50_000_000,
  localparam int IW = clog2_min1(LED_COUNT),
  localparam int MW = clog2_min1(NUM_MODES),
  localparam int FW = clog2_min1(FRAMES),
  localparam int CW = clog2_min1(TEX_WIDTH),
  localparam int AW = addr_width(NUM_MODES, FRAMES, LED_COUNT, TEX_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rev_pulse,
  input  logic [THETA_BITS-1:0] theta,
  input  logic                  px_req,
  input  logic [IW-1:0]         px_idx,
  input  logic                  mode_load,
  input  logic [MW-1:0]         mode_sel,
  input  logic [CW-1:0]         phase_offset,
  input  logic                  anim_en,
  output logic [AW-1:0]         rom_addr,
  output logic                  rom_rd,
  input  logic [PIX_W-1:0]      rom_data,
  output logic [PIX_W-1:0]      pixel_out,
  output logic                  pixel_valid,
  output logic [MW-1:0]         mode_active,
  output logic [FW-1:0]         frame_idx,
  output logic                  switching
);

  localparam int RW = clog2_min1(FRAME_DIV);

  pov_state_t    state;
  logic [MW-1:0] pend_mode;
  logic [RW-1:0] rev_cnt;
  logic          issued;
  logic          pass;
  logic          stalled;

  pov_addr_gen #(
    .LED_COUNT  (LED_COUNT),
    .TEX_WIDTH  (TEX_WIDTH),
    .THETA_BITS (THETA_BITS),
    .FRAMES     (FRAMES),
    .IW         (IW),
    .MW         (MW),
    .FW         (FW),
    .CW         (CW),
    .AW         (AW)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (px_req),
    .theta        (theta),
    .px_idx       (px_idx),
    .phase_offset (phase_offset),
    .mode         (mode_active),
    .frame        (frame_idx),
    .rom_addr     (rom_addr),
    .rom_rd       (rom_rd),
    .issued       (issued)
  );

`ifdef POV_STALL_BLANK_EN
  localparam int SW = clog2_min1(longint'(STALL_CYCLES) + 1);
  logic [SW-1:0] stall_cnt;

  // Revolution watchdog: saturating cycle count since the last rev_pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      stalled   <= 1'b0;
    end else if (rev_pulse) begin
      stall_cnt <= '0;
      stalled   <= 1'b0;
    end else if (stall_cnt == SW'(STALL_CYCLES)) begin
      stalled <= 1'b1;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stalled = 1'b0;
`endif

  // Mode-switch FSM plus animation frame counter; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pend_mode   <= '0;
      rev_cnt     <= '0;
      mode_active <= '0;
      frame_idx   <= '0;
      switching   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // A switch request wins over animation; a coincident rev_pulse is
          // not used as the switch boundary.
          if (mode_load && (mode_sel != mode_active)) begin
            state     <= PEND;
            pend_mode <= mode_sel;
            switching <= 1'b1;
          end else if (rev_pulse && anim_en) begin
            if (rev_cnt == RW'(FRAME_DIV - 1)) begin
              rev_cnt   <= '0;
              frame_idx <= (frame_idx == FW'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
            end else begin
              rev_cnt <= rev_cnt + 1'b1;
            end
          end
        end
        PEND: begin
          if (mode_load) begin
            pend_mode <= mode_sel;
          end
          if (rev_pulse) begin
            mode_active <= mode_load ? mode_sel : pend_mode;
            frame_idx   <= '0;
            rev_cnt     <= '0;
            state       <= BLANK;
          end
        end
        BLANK: begin
          if (rev_pulse) begin
            state     <= RUN;
            switching <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          switching <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: valid follows every issued request; the ROM data is only
  // passed through for real reads outside BLANK and outside a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      pass        <= 1'b0;
    end else begin
      pixel_valid <= issued;
      pass        <= rom_rd && (state != BLANK) && !stalled;
    end
  end

  assign pixel_out = pass ? rom_data : PIX_BLACK[PIX_W-1:0];

endmodule

// File: tb/tb_pov_frame_sequencer.sv
// Directed bench for pov_frame_sequencer with a behavioural texture ROM.
// Each ROM word is a fixed tag above its own address, so every returned
// pixel identifies the address that fetched it.
module tb_pov_frame_sequencer;

  localparam int AW = 19;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rev_pulse;
  logic [5:0]    theta;
  logic          px_req;
  logic [5:0]    px_idx;
  logic          mode_load;
  logic [1:0]    mode_sel;
  logic [7:0]    phase_offset;
  logic          anim_en;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [PW-1:0] rom_data;
  logic [PW-1:0] pixel_out;
  logic          pixel_valid;
  logic [1:0]    mode_active;
  logic [2:0]    frame_idx;
  logic          switching;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  pov_frame_sequencer #(
    .LED_COUNT    (52),
    .TEX_WIDTH    (256),
    .THETA_BITS   (6),
    .NUM_MODES    (4),
    .FRAMES       (8),
    .FRAME_DIV    (4),
    .PIX_W        (24),
    .STALL_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rev_pulse    (rev_pulse),
    .theta        (theta),
    .px_req       (px_req),
    .px_idx       (px_idx),
    .mode_load    (mode_load),
    .mode_sel     (mode_sel),
    .phase_offset (phase_offset),
    .anim_en      (anim_en),
    .rom_addr     (rom_addr),
    .rom_rd       (rom_rd),
    .rom_data     (rom_data),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .mode_active  (mode_active),
    .frame_idx    (frame_idx),
    .switching    (switching)
  );

  function automatic logic [PW-1:0] exp_pix(input logic [AW-1:0] a);
    return {5'b10101, a};
  endfunction

  // synchronous ROM model: data one cycle after rom_rd
  always @(posedge clk) begin
    if (rom_rd) rom_data <= exp_pix(rom_addr);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rev();
    rev_pulse = 1'b1;
    tick();
    rev_pulse = 1'b0;
    tick();
  endtask

  // single fetch: address/strobe at +1, pixel at +2, valid gone at +3
  task automatic fetch(input string tag, input logic [5:0] th, input logic [7:0] ph,
                       input logic [5:0] idx, input logic exp_rd,
                       input logic [AW-1:0] exp_addr, input logic [PW-1:0] exp_out);
    theta        = th;
    phase_offset = ph;
    px_idx       = idx;
    px_req       = 1'b1;
    tick();
    px_req = 1'b0;
    check({tag, "_rd"}, 32'(rom_rd), 32'(exp_rd));
    if (exp_rd) check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    check({tag, "_valid_early"}, 32'(pixel_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(pixel_valid), 32'd1);
    check({tag, "_pix"}, 32'(pixel_out), 32'(exp_out));
    tick();
    check({tag, "_valid_drop"}, 32'(pixel_valid), 32'd0);
  endtask

  initial begin
    int valids;
    rst_n        = 1'b0;
    rev_pulse    = 1'b0;
    theta        = '0;
    px_req       = 1'b0;
    px_idx       = '0;
    mode_load    = 1'b0;
    mode_sel     = '0;
    phase_offset = '0;
    anim_en      = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // reset state
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_pix", 32'(pixel_out), 32'd0);
    check("rst_rd", 32'(rom_rd), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_mode", 32'(mode_active), 32'd0);
    check("rst_frame", 32'(frame_idx), 32'd0);
    check("rst_switch", 32'(switching), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic fetch: col=4, (0*52+3)*256+4 = 772
    fetch("basic", 6'd1, 8'd0, 6'd3, 1'b1, 19'd772, exp_pix(19'd772));
    // column wrap: 252+10 = 262 -> 6
    fetch("wrap", 6'd63, 8'd10, 6'd0, 1'b1, 19'd6, exp_pix(19'd6));

    // animation: FRAME_DIV=4
    anim_en = 1'b1;
    repeat (3) pulse_rev();
    check("anim_3", 32'(frame_idx), 32'd0);
    pulse_rev();
    check("anim_4", 32'(frame_idx), 32'd1);
    repeat (3) pulse_rev();
    check("anim_7", 32'(frame_idx), 32'd1);
    pulse_rev();
    check("anim_8", 32'(frame_idx), 32'd2);
    // frame 2, led 1, col 0: ((0*8+2)*52+1)*256 = 26880
    fetch("frame2", 6'd0, 8'd0, 6'd1, 1'b1, 19'd26880, exp_pix(19'd26880));
    anim_en = 1'b0;
    repeat (4) pulse_rev();
    check("anim_freeze", 32'(frame_idx), 32'd2);

    // mode switch request coinciding with rev_pulse
    mode_sel  = 2'd2;
    mode_load = 1'b1;
    rev_pulse = 1'b1;
    tick();
    mode_load = 1'b0;
    rev_pulse = 1'b0;
    check("pend_switch", 32'(switching), 32'd1);
    check("pend_mode", 32'(mode_active), 32'd0);
    check("pend_frame", 32'(frame_idx), 32'd2);
    // overwrite pending mode twice, ending on 2
    mode_sel  = 2'd3;
    mode_load = 1'b1;
    tick();
    mode_sel = 2'd2;
    tick();
    mode_load = 1'b0;
    check("pend_hold", 32'(mode_active), 32'd0);
    pulse_rev();
    check("blank_mode", 32'(mode_active), 32'd2);
    check("blank_frame", 32'(frame_idx), 32'd0);
    check("blank_switch", 32'(switching), 32'd1);
    // ((2*8+0)*52+3)*256+4 = 213764, pixel forced black
    fetch("blank", 6'd1, 8'd0, 6'd3, 1'b1, 19'd213764, 24'd0);
    pulse_rev();
    check("run_switch", 32'(switching), 32'd0);
    fetch("newmode", 6'd1, 8'd0, 6'd3, 1'b1, 19'd213764, exp_pix(19'd213764));
    mode_sel  = 2'd2;
    mode_load = 1'b1;
    tick();
    mode_load = 1'b0;
    check("same_mode_ignored", 32'(switching), 32'd0);

    // out-of-range LED index
    fetch("oor", 6'd1, 8'd0, 6'd52, 1'b0, 19'd0, 24'd0);

    // back-to-back requests, mode 2 frame 0, col 0: (832+c)*256
    pulse_rev();
    valids = 0;
    for (int c = 0; c < 12; c++) begin
      theta  = '0;
      px_idx = 6'(c);
      px_req = (c < 10);
      if (c < 10) exp_q.push_back(exp_pix(19'((832 + c) * 256)));
      tick();
      if (pixel_valid) begin
        valids++;
        if (exp_q.size() > 0) check("b2b_pix", 32'(pixel_out), 32'(exp_q.pop_front()));
        else check("b2b_extra", 32'd1, 32'd0);
      end
    end
    px_req = 1'b0;
    check("b2b_count", 32'(valids), 32'd10);
    check("b2b_drain", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a fetch drops the pixel
    px_idx = 6'd0;
    px_req = 1'b1;
    tick();
    px_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(pixel_valid), 32'd0);
    check("midrst_rd", 32'(rom_rd), 32'd0);
    check("midrst_mode", 32'(mode_active), 32'd0);
    tick();
    check("midrst_valid_hold", 32'(pixel_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_valid_after", 32'(pixel_valid), 32'd0);

`ifdef POV_STALL_BLANK_EN
    // rotor stall: no rev_pulse for more than STALL_CYCLES
    pulse_rev();
    repeat (105) tick();
    fetch("stall", 6'd1, 8'd0, 6'd3, 1'b1, 19'd772, 24'd0);
    pulse_rev();
    fetch("stall_clear", 6'd1, 8'd0, 6'd3, 1'b1, 19'd772, exp_pix(19'd772));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
